// File: rtl/sp_array_pkg.sv
// Shared definitions for the single-port SRAM array arbiter.
//
// Contents:
//   SpDepth / SpAddrW / SpDataW - default geometry of the SRAM array
//   resp_t                      - read response record (data, err)
//   prio_e                      - round-robin priority pointer encoding
//   sp_in_range()               - address range check against a word count

package sp_array_pkg;

  localparam int unsigned SpDepth = 3072;
  localparam int unsigned SpAddrW = 12;
  localparam int unsigned SpDataW = 32;

  // Read response as seen on the response channel.
  typedef struct packed {
    logic [SpDataW-1:0] data;
    logic               err;
  } resp_t;

  // Which channel wins the next contended cycle.
  typedef enum logic {
    PrioRead  = 1'b0,
    PrioWrite = 1'b1
  } prio_e;

  // True when a word address lies inside an array of 'depth' words.
  function automatic logic sp_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/sp_array_resp_fifo.sv
// Two-entry first-word-fall-through FIFO holding read responses.
//
// An entry offered on the input while the FIFO is empty is visible on the
// output in the same cycle; if the consumer takes it, it is never stored.
// Otherwise it is stored and presented unchanged until popped.
//
// Ports:
//   clock, reset                 - clock and synchronous active-high reset
//   in_valid, in_ready           - enqueue handshake
//   in_data, in_err              - enqueued response payload
//   out_valid, out_ready         - dequeue handshake
//   out_data, out_err            - head-of-queue payload

module sp_array_resp_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        err_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic empty;
  logic bypass;
  logic store;
  logic pop;

  assign empty    = (count_q == 2'd0);
  assign in_ready = (count_q != 2'd2);

  // Empty FIFO with an arriving entry that is consumed at once: pass through.
  assign bypass = empty & in_valid & out_ready;
  assign store  = in_valid & in_ready & ~bypass;
  assign pop    = ~empty & out_ready;

  always_comb begin
    out_valid = ~empty | in_valid;
    out_data  = empty ? in_data : data_q[rd_ptr_q];
    out_err   = empty ? in_err  : err_q[rd_ptr_q];
  end

  always_comb begin
    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (store) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (store) begin
      data_q[wr_ptr_q] <= in_data;
      err_q[wr_ptr_q]  <= in_err;
    end
  end

endmodule

// File: rtl/sp_array_arbiter.sv
// Arbiter sharing one single-port RW SRAM (1-cycle read latency) between a
// read request channel and a write request channel, with a read response
// channel backed by a two-entry response FIFO.
//
// At most one SRAM access is issued per cycle. Reads are limited to two
// outstanding credits (in flight plus queued), so the response FIFO can
// never overflow. When both channels compete, a one-bit round-robin pointer
// picks the winner and then points at the loser. Out-of-range addresses never
// reach the SRAM: writes are dropped, reads return data 0 with err set.
//
// Ports:
//   clock, reset                           - clock, synchronous active-high reset
//   rd_req_valid/ready/addr                - read request channel
//   wr_req_valid/ready/addr/data           - write request channel
//   rd_resp_valid/ready/data/err           - read response channel
//   sram_addr/en/wmode/wdata, sram_rdata   - SRAM port

module sp_array_arbiter
  import sp_array_pkg::*;
#(
  parameter int unsigned DEPTH  = SpDepth,
  parameter int unsigned ADDR_W = SpAddrW,
  parameter int unsigned DATA_W = SpDataW
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,

  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,

  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_err,

  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Credits: reads in flight plus responses queued (0..2).
  logic [1:0] credits_q, credits_d;
  prio_e      prio_q, prio_d;

  // Read issued last cycle; its SRAM data (or error) is valid this cycle.
  logic pend_q, pend_d;
  logic pend_oob_q, pend_oob_d;

  logic rd_in_range;
  logic wr_in_range;
  logic resp_fire;
  logic rd_eligible;
  logic rd_cand;
  logic contended;
  logic rd_fire;
  logic wr_fire;

  logic              fifo_in_valid;
  logic              fifo_in_ready;
  logic [DATA_W-1:0] fifo_in_data;
  logic              fifo_in_err;
  logic              fifo_out_valid;
  logic              fifo_out_ready;
  logic [DATA_W-1:0] fifo_out_data;
  logic              fifo_out_err;

  assign rd_in_range = sp_in_range(32'(rd_req_addr), DEPTH);
  assign wr_in_range = sp_in_range(32'(wr_req_addr), DEPTH);

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------

  assign rd_resp_valid  = fifo_out_valid & ~reset;
  assign rd_resp_data   = fifo_out_data;
  assign rd_resp_err    = fifo_out_err;
  assign fifo_out_ready = rd_resp_ready & ~reset;
  assign resp_fire      = rd_resp_valid & rd_resp_ready;

  // Out-of-range reads never touched the SRAM, so substitute zero data.
  assign fifo_in_valid = pend_q & ~reset & fifo_in_ready;
  assign fifo_in_data  = pend_oob_q ? '0 : sram_rdata;
  assign fifo_in_err   = pend_oob_q;

  sp_array_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (fifo_in_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (fifo_in_data),
    .in_err    (fifo_in_err),
    .out_valid (fifo_out_valid),
    .out_ready (fifo_out_ready),
    .out_data  (fifo_out_data),
    .out_err   (fifo_out_err)
  );

  // ---------------------------------------------------------------------------
  // Request arbitration
  // ---------------------------------------------------------------------------

  // A response leaving this cycle frees its credit for a read in the same
  // cycle. resp_fire depends only on registered state and rd_resp_ready, so
  // sram_rdata never reaches a ready.
  assign rd_eligible = (credits_q < 2'd2) | resp_fire;
  assign rd_cand     = rd_req_valid & rd_eligible;
  assign contended   = rd_cand & wr_req_valid;

  assign rd_req_ready = ~reset & rd_eligible & (~wr_req_valid | (prio_q == PrioRead));
  assign wr_req_ready = ~reset & (~rd_cand | (prio_q == PrioWrite));

  assign rd_fire = rd_req_valid & rd_req_ready;
  assign wr_fire = wr_req_valid & wr_req_ready;

  always_comb begin
    prio_d = prio_q;
    if (contended && !reset) begin
      prio_d = (prio_q == PrioRead) ? PrioWrite : PrioRead;
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({rd_fire, resp_fire})
      2'b10:   credits_d = credits_q + 2'd1;
      2'b01:   credits_d = credits_q - 2'd1;
      default: credits_d = credits_q;
    endcase
  end

  assign pend_d     = rd_fire;
  assign pend_oob_d = ~rd_in_range;

  // ---------------------------------------------------------------------------
  // SRAM port: idle outputs are held at zero
  // ---------------------------------------------------------------------------

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (rd_fire && rd_in_range) begin
      sram_en   = 1'b1;
      sram_addr = rd_req_addr;
    end else if (wr_fire && wr_in_range) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_req_addr;
      sram_wdata = wr_req_data;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  always_ff @(posedge clock) begin
    if (reset) begin
      credits_q  <= 2'd0;
      prio_q     <= PrioRead;
      pend_q     <= 1'b0;
      pend_oob_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      prio_q     <= prio_d;
      pend_q     <= pend_d;
      pend_oob_q <= pend_oob_d;
    end
  end

endmodule
